// File: rtl/m10k_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : m10k_rd_arbiter
//  Purpose  : Shares the read ports of an m10k_banks instance among N_REQ
//             requesters. Each bank runs its own round-robin arbiter, drives
//             its en/addr in the grant cycle, tracks every in-flight read
//             through the fixed bank latency and routes the returning word
//             back to the requester that issued it.
//  Revision : 1.0 - initial release
// ============================================================================
module m10k_rd_arbiter #(
  parameter  int N_REQ          = 4,
  parameter  int N_BANKS        = 4,
  parameter  int DEPTH_PER_BANK = 16,
  parameter  int W              = 32,
  parameter  int READ_LATENCY   = 3,
  localparam int AW             = $clog2(DEPTH_PER_BANK),
  localparam int BW             = $clog2(N_BANKS),
  localparam int RW             = $clog2(N_REQ)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  // requester side
  input  logic [N_REQ-1:0]                req_valid_i,
  input  logic [N_REQ-1:0][BW-1:0]        req_bank_i,
  input  logic [N_REQ-1:0][AW-1:0]        req_addr_i,
  output logic [N_REQ-1:0]                req_ready_o,
  output logic [N_REQ-1:0]                rsp_valid_o,
  output logic [N_REQ-1:0][W-1:0]         rsp_data_o,
  // bank read ports
  output logic [N_BANKS-1:0]              b_en_o,
  output logic [N_BANKS-1:0][AW-1:0]      b_addr_o,
  input  logic [N_BANKS-1:0][W-1:0]       b_dout_i
);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  // Which requesters are asking for which bank this cycle
  logic [N_BANKS-1:0][N_REQ-1:0]               w_cand;
  // Per-bank grant and winning requester
  logic [N_BANKS-1:0]                          w_gnt;
  logic [N_BANKS-1:0][RW-1:0]                  w_win;
  // Search scratch for the rotating priority scan
  logic [RW:0]                                 w_sum;
  logic [RW-1:0]                               w_idx;
  // Per-requester acceptance, before reset gating
  logic [N_REQ-1:0]                            w_ready;

  // Round-robin pointers, one per bank
  logic [N_BANKS-1:0][RW-1:0]                  rr_ptr_q, rr_ptr_d;
  // Last granted address per bank (held while the bank is idle)
  logic [N_BANKS-1:0][AW-1:0]                  b_addr_q, b_addr_d;
  // In-flight read tracker: one {vld,id} shift register per bank
  logic [N_BANKS-1:0][READ_LATENCY-1:0]        trk_vld_q, trk_vld_d;
  logic [N_BANKS-1:0][READ_LATENCY-1:0][RW-1:0] trk_id_q, trk_id_d;
  // Registered response
  logic [N_REQ-1:0]                            rsp_valid_q, rsp_valid_d;
  logic [N_REQ-1:0][W-1:0]                     rsp_data_q, rsp_data_d;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  // Each requester presents exactly one bank, so it is a candidate on at most one bank
  always_comb begin
    w_cand = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      for (int r = 0; r < N_REQ; r++) begin
        if (req_valid_i[r] && (req_bank_i[r] == BW'(b))) begin
          w_cand[b][r] = 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  // Per bank, pick the first candidate at or after rr_ptr, wrapping modulo N_REQ
  always_comb begin
    w_gnt = '0;
    w_win = '0;
    w_sum = '0;
    w_idx = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      for (int k = 0; k < N_REQ; k++) begin
        // ptr and k are both below N_REQ, so one subtraction is enough to wrap
        w_sum = {1'b0, rr_ptr_q[b]} + (RW+1)'(k);
        if (w_sum >= (RW+1)'(N_REQ)) begin
          w_sum = w_sum - (RW+1)'(N_REQ);
        end
        w_idx = w_sum[RW-1:0];
        if (!w_gnt[b] && w_cand[b][w_idx]) begin
          w_gnt[b] = 1'b1;
          w_win[b] = w_idx;
        end
      end
    end
  end

  // A requester is accepted when the bank it targets picked it this cycle
  always_comb begin
    w_ready = '0;
    for (int r = 0; r < N_REQ; r++) begin
      w_ready[r] = req_valid_i[r]
                && w_gnt[req_bank_i[r]]
                && (w_win[req_bank_i[r]] == RW'(r));
    end
  end

  // Advance the pointer past the winner; an idle bank keeps its pointer
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    for (int b = 0; b < N_BANKS; b++) begin
      if (w_gnt[b]) begin
        if (w_win[b] == RW'(N_REQ - 1)) begin
          rr_ptr_d[b] = '0;
        end else begin
          rr_ptr_d[b] = w_win[b] + RW'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Bank drive
  // --------------------------------------------------------------------------
  // Route the winner's address to the bank; keep the previous address when idle
  always_comb begin
    b_addr_d = b_addr_q;
    for (int b = 0; b < N_BANKS; b++) begin
      if (w_gnt[b]) begin
        b_addr_d[b] = req_addr_i[w_win[b]];
      end
    end
  end

  // Handshake and bank strobes are forced low while reset is asserted, whatever the inputs
  assign req_ready_o = rst_n ? w_ready  : '0;
  assign b_en_o      = rst_n ? w_gnt    : '0;
  assign b_addr_o    = rst_n ? b_addr_d : '0;

  // --------------------------------------------------------------------------
  // In-flight tracking
  // --------------------------------------------------------------------------
  // Stage 0 captures this cycle's grant; the last stage lines up with valid b_dout
  always_comb begin
    trk_vld_d = trk_vld_q;
    trk_id_d  = trk_id_q;
    for (int b = 0; b < N_BANKS; b++) begin
      trk_vld_d[b][0] = w_gnt[b];
      trk_id_d[b][0]  = w_win[b];
      for (int s = 1; s < READ_LATENCY; s++) begin
        trk_vld_d[b][s] = trk_vld_q[b][s-1];
        trk_id_d[b][s]  = trk_id_q[b][s-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response steering
  // --------------------------------------------------------------------------
  // Reads retiring together were granted together, so their ids never collide
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    for (int b = 0; b < N_BANKS; b++) begin
      if (trk_vld_q[b][READ_LATENCY-1]) begin
        rsp_valid_d[trk_id_q[b][READ_LATENCY-1]] = 1'b1;
        rsp_data_d[trk_id_q[b][READ_LATENCY-1]]  = b_dout_i[b];
      end
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  // Control state; reset discards every in-flight read and restarts rotation at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      b_addr_q    <= '0;
      trk_vld_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      b_addr_q    <= b_addr_d;
      trk_vld_q   <= trk_vld_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Requester ids only matter alongside a set vld bit, so they carry no reset
  always_ff @(posedge clk) begin
    trk_id_q <= trk_id_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_m10k_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_m10k_rd_arbiter
//  Purpose  : Directed self-checking bench for m10k_rd_arbiter with a
//             behavioural m10k bank read-port model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_m10k_rd_arbiter;

  localparam int N_REQ = 4;
  localparam int N_BANKS = 4;
  localparam int DEPTH = 16;
  localparam int W = 32;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N_REQ-1:0]              req_valid;
  logic [N_REQ-1:0][1:0]         req_bank;
  logic [N_REQ-1:0][3:0]         req_addr;
  logic [N_REQ-1:0]              req_ready;
  logic [N_REQ-1:0]              rsp_valid;
  logic [N_REQ-1:0][W-1:0]       rsp_data;
  logic [N_BANKS-1:0]            b_en;
  logic [N_BANKS-1:0][3:0]       b_addr;
  logic [N_BANKS-1:0][W-1:0]     b_dout;

  always #5 clk = ~clk;

  m10k_rd_arbiter #(
    .N_REQ(N_REQ), .N_BANKS(N_BANKS), .DEPTH_PER_BANK(DEPTH),
    .W(W), .READ_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_bank_i(req_bank), .req_addr_i(req_addr),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .b_en_o(b_en), .b_addr_o(b_addr), .b_dout_i(b_dout)
  );

  // Bank model: sample en/addr at the edge, data valid LAT cycles later
  logic [W-1:0] mem  [N_BANKS][DEPTH];
  logic [W-1:0] pipe [N_BANKS][LAT];

  always @(posedge clk) begin
    for (int b = 0; b < N_BANKS; b++) begin
      if (b_en[b]) pipe[b][0] <= mem[b][b_addr[b]];
      for (int s = 1; s < LAT; s++) pipe[b][s] <= pipe[b][s-1];
    end
  end

  always_comb begin
    for (int b = 0; b < N_BANKS; b++) b_dout[b] = pipe[b][LAT-1];
  end

  // Expected responses indexed by cycle number
  bit [N_REQ-1:0] exp_rv [4096];
  bit [W-1:0]     exp_rd [4096][N_REQ];
  int cyc = 0;
  int total = 0;
  int bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic expect_rsp(input int c, input int r, input logic [W-1:0] d);
    exp_rv[c][r] = 1'b1;
    exp_rd[c][r] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'b1111;
    req_bank  = {2'd3, 2'd2, 2'd1, 2'd0};
    req_addr  = {4'd4, 4'd3, 4'd2, 4'd1};
    repeat (2) @(posedge clk);
    #2;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    total++; if (b_en !== 4'b0000) begin bad++; $display("FAIL reset_b_en got=%b exp=0000", b_en); end
    total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
    total++; if (rsp_data !== '0) begin bad++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    total++; if (b_addr !== 16'h0000) begin bad++; $display("FAIL reset_b_addr got=%h exp=0000", b_addr); end
    req_valid = 4'b0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    #2;
    total++; if (b_en !== 4'b0000) begin bad++; $display("FAIL idle_b_en got=%b exp=0000", b_en); end
  endtask

  task automatic test_single_read();
    tick();
    req_valid = 4'b0001; req_bank[0] = 2'd2; req_addr[0] = 4'd5;
    #2;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    total++; if (b_en !== 4'b0100) begin bad++; $display("FAIL single_b_en got=%b exp=0100", b_en); end
    total++; if (b_addr[2] !== 4'd5) begin bad++; $display("FAIL single_b_addr got=%0d exp=5", b_addr[2]); end
    expect_rsp(cyc + 4, 0, 32'h0205A55A);
    for (int k = 1; k <= 6; k++) begin
      tick();
      req_valid = 4'b0000;
      #2;
      if (k == 1) begin
        total++; if (b_en !== 4'b0000 || b_addr[2] !== 4'd5) begin
          bad++; $display("FAIL single_addr_hold got en=%b addr=%0d exp en=0000 addr=5", b_en, b_addr[2]);
        end
      end
      total++;
      if (rsp_valid !== exp_rv[cyc]) begin bad++; $display("FAIL single_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rv[cyc]); end
      for (int r = 0; r < N_REQ; r++) if (exp_rv[cyc][r]) begin
        total++;
        if (rsp_data[r] !== exp_rd[cyc][r]) begin bad++; $display("FAIL single_rsp_data r=%0d got=%h exp=%h", r, rsp_data[r], exp_rd[cyc][r]); end
      end
    end
  endtask

  task automatic test_contention();
    int seq [8] = '{0, 1, 2, 3, 1, 3, 1, 3};
    logic [N_REQ-1:0] pend;
    pend = 4'b1111;
    req_bank = {4{2'd1}};
    req_addr = {4'd3, 4'd2, 4'd1, 4'd0};
    for (int i = 0; i < 14; i++) begin
      tick();
      if (i < 4)      req_valid = pend;
      else if (i < 8) req_valid = 4'b1010;
      else            req_valid = 4'b0000;
      #2;
      if (i < 8) begin
        total++;
        if (req_ready !== (4'b0001 << seq[i]) || b_en !== 4'b0010 || b_addr[1] !== 4'(seq[i])) begin
          bad++; $display("FAIL contention_grant step=%0d got ready=%b en=%b addr=%0d exp winner=%0d", i, req_ready, b_en, b_addr[1], seq[i]);
        end
        expect_rsp(cyc + 4, seq[i], mem[1][seq[i]]);
        if (i < 4) pend[seq[i]] = 1'b0;
      end
      total++;
      if (rsp_valid !== exp_rv[cyc]) begin bad++; $display("FAIL contention_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rv[cyc]); end
      for (int r = 0; r < N_REQ; r++) if (exp_rv[cyc][r]) begin
        total++;
        if (rsp_data[r] !== exp_rd[cyc][r]) begin bad++; $display("FAIL contention_rsp_data r=%0d got=%h exp=%h", r, rsp_data[r], exp_rd[cyc][r]); end
      end
    end
  endtask

  task automatic test_parallel();
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) begin
        req_valid = 4'b1111;
        req_bank  = {2'd3, 2'd2, 2'd1, 2'd0};
        req_addr  = {4{4'd7}};
      end else begin
        req_valid = 4'b0000;
      end
      #2;
      if (i == 0) begin
        total++; if (req_ready !== 4'b1111) begin bad++; $display("FAIL parallel_ready got=%b exp=1111", req_ready); end
        total++; if (b_en !== 4'b1111 || b_addr !== 16'h7777) begin
          bad++; $display("FAIL parallel_bank got en=%b addr=%h exp en=1111 addr=7777", b_en, b_addr);
        end
        for (int r = 0; r < N_REQ; r++) expect_rsp(cyc + 4, r, {8'(r), 8'h07, 16'hB00B});
      end
      total++;
      if (rsp_valid !== exp_rv[cyc]) begin bad++; $display("FAIL parallel_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rv[cyc]); end
      for (int r = 0; r < N_REQ; r++) if (exp_rv[cyc][r]) begin
        total++;
        if (rsp_data[r] !== exp_rd[cyc][r]) begin bad++; $display("FAIL parallel_rsp_data r=%0d got=%h exp=%h", r, rsp_data[r], exp_rd[cyc][r]); end
      end
    end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 22; i++) begin
      tick();
      if (i < 16) begin
        req_valid = 4'b0001; req_bank[0] = 2'd3; req_addr[0] = 4'(i);
      end else begin
        req_valid = 4'b0000;
      end
      #2;
      if (i < 16) begin
        total++;
        if (req_ready !== 4'b0001 || b_en !== 4'b1000 || b_addr[3] !== 4'(i)) begin
          bad++; $display("FAIL stream_issue i=%0d got ready=%b en=%b addr=%0d exp ready=0001 en=1000 addr=%0d", i, req_ready, b_en, b_addr[3], i);
        end
        expect_rsp(cyc + 4, 0, mem[3][i]);
      end
      total++;
      if (rsp_valid !== exp_rv[cyc]) begin bad++; $display("FAIL stream_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rv[cyc]); end
      for (int r = 0; r < N_REQ; r++) if (exp_rv[cyc][r]) begin
        total++;
        if (rsp_data[r] !== exp_rd[cyc][r]) begin bad++; $display("FAIL stream_rsp_data r=%0d got=%h exp=%h", r, rsp_data[r], exp_rd[cyc][r]); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 3; i++) begin
      tick();
      req_valid = 4'b0001; req_bank[0] = 2'd0; req_addr[0] = 4'(i + 1);
      #2;
      expect_rsp(cyc + 4, 0, mem[0][i + 1]);
    end
    tick();
    req_valid = 4'b1111; req_bank = {4{2'd0}};
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0000 || b_en !== 4'b0000) begin
      bad++; $display("FAIL midreset_drive got ready=%b en=%b exp 0000/0000", req_ready, b_en);
    end
    total++; if (rsp_valid !== 4'b0000 || rsp_data !== '0 || b_addr !== 16'h0000) begin
      bad++; $display("FAIL midreset_regs got rv=%b addr=%h data=%h exp all zero", rsp_valid, b_addr, rsp_data);
    end
    for (int c = cyc; c < cyc + 12; c++) exp_rv[c] = '0;
    // Release one edge later; first post-reset cycle arbitrates from pointer 0
    tick();
    rst_n = 1'b1;
    req_valid = 4'b0011; req_bank = {4{2'd0}}; req_addr = {4'd0, 4'd0, 4'd10, 4'd9};
    #2;
    total++; if (req_ready !== 4'b0001 || b_en !== 4'b0001 || b_addr[0] !== 4'd9) begin
      bad++; $display("FAIL postreset_grant got ready=%b en=%b addr=%0d exp ready=0001 en=0001 addr=9", req_ready, b_en, b_addr[0]);
    end
    expect_rsp(cyc + 4, 0, mem[0][9]);
    for (int i = 0; i < 8; i++) begin
      tick();
      req_valid = 4'b0000;
      #2;
      total++;
      if (rsp_valid !== exp_rv[cyc]) begin bad++; $display("FAIL midreset_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rv[cyc]); end
      for (int r = 0; r < N_REQ; r++) if (exp_rv[cyc][r]) begin
        total++;
        if (rsp_data[r] !== exp_rd[cyc][r]) begin bad++; $display("FAIL midreset_rsp_data r=%0d got=%h exp=%h", r, rsp_data[r], exp_rd[cyc][r]); end
      end
    end
  endtask

  task automatic test_fairness();
    int wt [N_REQ];
    int cnt [N_REQ];
    logic [N_REQ-1:0] hold;
    int mx, mn;
    hold = '0;
    req_bank = {4{2'd2}};
    for (int r = 0; r < N_REQ; r++) begin wt[r] = 0; cnt[r] = 0; end
    for (int i = 0; i < 1000; i++) begin
      tick();
      for (int r = 0; r < N_REQ; r++) begin
        if (i >= 500) req_valid[r] = 1'b1;
        else if (!hold[r]) req_valid[r] = 1'($urandom_range(0, 1));
        if (!hold[r]) req_addr[r] = 4'($urandom_range(0, 15));
      end
      #2;
      total++;
      if (req_valid == 4'b0000) begin
        if (req_ready !== 4'b0000 || b_en !== 4'b0000) begin
          bad++; $display("FAIL fair_idle cyc=%0d got ready=%b en=%b exp 0000", cyc, req_ready, b_en);
        end
      end else if (!$onehot(req_ready) || (req_ready & ~req_valid) != 4'b0000 || b_en !== 4'b0100) begin
        bad++; $display("FAIL fair_grant cyc=%0d got ready=%b en=%b valid=%b exp one granted, en=0100", cyc, req_ready, b_en, req_valid);
      end
      for (int r = 0; r < N_REQ; r++) begin
        if (req_ready[r]) begin
          wt[r] = 0;
          if (i >= 500) cnt[r]++;
        end else if (req_valid[r]) begin
          wt[r]++;
          total++;
          if (wt[r] > N_REQ - 1) begin bad++; $display("FAIL fair_wait r=%0d cyc=%0d got=%0d exp<=%0d", r, cyc, wt[r], N_REQ - 1); end
        end
        hold[r] = req_valid[r] & ~req_ready[r];
      end
    end
    mx = cnt[0]; mn = cnt[0];
    for (int r = 1; r < N_REQ; r++) begin
      if (cnt[r] > mx) mx = cnt[r];
      if (cnt[r] < mn) mn = cnt[r];
    end
    total++;
    if (mx - mn > 1) begin bad++; $display("FAIL fair_counts got max=%0d min=%0d exp diff<=1", mx, mn); end
    tick();
    req_valid = 4'b0000;
    repeat (6) tick();
  endtask

  initial begin
    for (int b = 0; b < N_BANKS; b++)
      for (int a = 0; a < DEPTH; a++)
        mem[b][a] = {8'(b), 8'(a), 16'hB00B};
    mem[2][5] = 32'h0205A55A;
    for (int c = 0; c < 4096; c++) exp_rv[c] = '0;
    req_valid = '0;
    req_bank  = '0;
    req_addr  = '0;

    test_reset();
    test_single_read();
    test_contention();
    test_parallel();
    test_streaming();
    test_reset_midflight();
    test_fairness();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
